// File: rtl/led_pattern_gen.sv
// led_pattern_gen: divider-stepped LED pattern generator with a debounced, active-low mode button.
// Define LED_PATTERN_GEN_PWM_EN to gate the LEDs with an 8-bit global brightness PWM.
module led_pattern_gen #(
    parameter int N_LEDS          = 17,
    parameter int CLK_HZ          = 25_000_000,
    parameter int STEP_HZ         = 16,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              btn_i,
    input  logic              en_i,
    input  logic [7:0]        brightness_i,
    output logic [N_LEDS-1:0] led_o,
    output logic [1:0]        mode_o,
    output logic              step_o
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {CHASE_L, CHASE_R, BOUNCE, COUNT} mode_t;

    mode_t             mode, mode_nxt;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     dcnt;
    logic              sync1, sync2, stable, dir, dir_nxt;
    logic              tick, accept, press, empty;
    logic [N_LEDS-1:0] pattern, pat_nxt, shifted;

    function automatic logic [N_LEDS-1:0] init_of(mode_t m);
        return m == CHASE_R ? {1'b1, {(N_LEDS-1){1'b0}}} : m == COUNT ? {N_LEDS{1'b0}} : N_LEDS'(1);
    endfunction

    assign tick     = cnt == CW'(DIV - 1) && en_i;
    assign accept   = sync2 != stable && dcnt == DW'(DEBOUNCE_CYCLES - 1);
    assign press    = accept && !sync2;
    assign empty    = pattern == '0 && mode != COUNT;
    assign mode_nxt = press ? mode_t'(mode + 2'd1) : mode;
    assign mode_o   = mode;

    // dir: 0 = shifting up (left), 1 = shifting down (right)
    always_comb begin
        shifted = mode == CHASE_L ? {pattern[N_LEDS-2:0], pattern[N_LEDS-1]}
                : mode == CHASE_R ? {pattern[0], pattern[N_LEDS-1:1]}
                : mode == COUNT   ? pattern + N_LEDS'(1)
                : dir             ? pattern >> 1 : pattern << 1;
        pat_nxt = press || empty ? init_of(mode_nxt) : tick ? shifted : pattern;
        dir_nxt = press || empty ? 1'b0
                : !tick || mode != BOUNCE ? dir
                : shifted[N_LEDS-1] ? 1'b1 : shifted[0] ? 1'b0 : dir;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {sync2, sync1} <= 2'b11;
            stable         <= 1'b1;
            dcnt           <= '0;
            cnt            <= '0;
            mode           <= CHASE_L;
            pattern        <= N_LEDS'(1);
            dir            <= 1'b0;
            step_o         <= 1'b0;
        end else begin
            {sync2, sync1} <= {sync1, btn_i};
            dcnt           <= sync2 == stable || accept ? '0 : dcnt + DW'(1);
            if (accept) stable <= sync2;
            cnt            <= press || tick ? '0 : en_i ? cnt + CW'(1) : cnt;
            mode           <= mode_nxt;
            pattern        <= pat_nxt;
            dir            <= dir_nxt;
            step_o         <= tick && !press && !empty;
        end
    end

`ifdef LED_PATTERN_GEN_PWM_EN
    logic [7:0]        pwm_cnt;
    logic [N_LEDS-1:0] led_q;
    logic              gate;
    assign gate  = pwm_cnt < brightness_i || brightness_i == 8'hFF;
    assign led_o = led_q;
    // Gate the next pattern so the LED register adds no latency over the pattern register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt <= '0;
            led_q   <= N_LEDS'(1);
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led_q   <= pat_nxt & {N_LEDS{gate}};
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness_i;
    assign led_o = pattern;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of led_pattern_gen with N_LEDS=4, DIV=4, DEBOUNCE_CYCLES=3.
module tb_led_pattern_gen;
    logic       clk = 1'b0, rst_n = 1'b0, btn = 1'b1, en = 1'b1;
    logic [7:0] brightness = 8'hFF;
    logic [3:0] led;
    logic [1:0] mode;
    logic       step;
    int         n_pass = 0, n_total = 0;
    logic [3:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LEDS(4), .CLK_HZ(8), .STEP_HZ(2), .DEBOUNCE_CYCLES(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .en_i(en), .brightness_i(brightness),
        .led_o(led), .mode_o(mode), .step_o(step)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Starts with the divider at 0; ends on the step edge with the divider back at 0
    task automatic expect_step(input logic [3:0] exp);
        @(negedge clk);
        check("step_pulse_width", 32'(step), 0);
        repeat (2) @(negedge clk);
        check("no_early_step", 32'(step), 0);
        @(negedge clk);
        check("step_led", 32'(led), 32'(exp));
        check("step_pulse", 32'(step), 1);
    endtask

    // Mode changes on the 5th edge after btn falls; release is settled with the divider frozen
    task automatic press_btn(input logic [1:0] old_mode, input logic [1:0] new_mode, input logic [3:0] exp_led);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        check("mode_before_press", 32'(mode), 32'(old_mode));
        @(negedge clk);
        check("mode_after_press", 32'(mode), 32'(new_mode));
        check("led_reload", 32'(led), 32'(exp_led));
        check("no_step_on_press", 32'(step), 0);
        en  = 1'b0;
        btn = 1'b1;
        repeat (6) @(negedge clk);
        check("release_no_event", 32'(mode), 32'(new_mode));
        en = 1'b1;
    endtask

    initial begin
        int hits;
        @(negedge clk);
        check("rst_led", 32'(led), 1);
        check("rst_mode", 32'(mode), 0);
        check("rst_step", 32'(step), 0);
        rst_n = 1'b1;
        expect_step(4'b0010);
        expect_step(4'b0100);
        expect_step(4'b1000);
        expect_step(4'b0001);
        press_btn(2'd0, 2'd1, 4'b1000);
        expect_step(4'b0100);
        expect_step(4'b0010);
        expect_step(4'b0001);
        expect_step(4'b1000);
        press_btn(2'd1, 2'd2, 4'b0001);
        for (int i = 0; i < 7; i++) expect_step(bounce_seq[i]);
        press_btn(2'd2, 2'd3, 4'b0000);
        for (int i = 1; i <= 16; i++) expect_step(4'(i));
        press_btn(2'd3, 2'd0, 4'b0001);
        expect_step(4'b0010);
        // freeze with divider at 2: one more enabled edge reaches 3, the next steps
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("freeze_led", 32'(led), 32'(4'b0010));
        check("freeze_step", 32'(step), 0);
        en = 1'b1;
        @(negedge clk);
        check("thaw_no_step", 32'(step), 0);
        check("thaw_led_hold", 32'(led), 32'(4'b0010));
        @(negedge clk);
        check("thaw_step_led", 32'(led), 32'(4'b0100));
        check("thaw_step", 32'(step), 1);
        en  = 1'b0;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_mode", 32'(mode), 0);
        check("glitch_led", 32'(led), 32'(4'b0100));
        btn = 1'b0;
        repeat (8) @(negedge clk);
        check("long_press_mode", 32'(mode), 1);
        check("long_press_led", 32'(led), 32'(4'b1000));
        btn = 1'b1;
        repeat (6) @(negedge clk);
        check("long_release_mode", 32'(mode), 1);
        en = 1'b1;
        expect_step(4'b0100);
        repeat (3) @(negedge clk);
        press_btn(2'd1, 2'd2, 4'b0001);
        expect_step(4'b0010);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 1);
        check("async_rst_mode", 32'(mode), 0);
        check("async_rst_step", 32'(step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_step(4'b0010);
`ifdef LED_PATTERN_GEN_PWM_EN
        en         = 1'b0;
        brightness = 8'd64;
        @(negedge clk);
        hits = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led == 4'b0010) hits++;
        end
        check("pwm_64_on_cycles", 32'(hits), 64);
        brightness = 8'd0;
        @(negedge clk);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (led == 4'b0000) hits++;
        end
        check("pwm_0_off", 32'(hits), 20);
        brightness = 8'hFF;
        @(negedge clk);
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (led == 4'b0010) hits++;
        end
        check("pwm_255_on", 32'(hits), 300);
        en = 1'b1;
`else
        hits = 0;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
